// File: rtl/fetch_instr_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the fetch -> decode instruction queue.
//   - IQ_DEPTH   : default number of queue entries (power of two, >= 2)
//   - iq_entry_t : one queued fetch result {pc, instr, err} at the global
//                  ADDR_WIDTH / DATA_WIDTH
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package fetch_pkg;

    localparam int IQ_DEPTH = 4;

    // err marks a word whose AXI-lite RRESP was not OKAY; it stays with the word.
    typedef struct packed {
        logic [`ADDR_WIDTH-1:0] pc;
        logic [`DATA_WIDTH-1:0] instr;
        logic                   err;
    } iq_entry_t;

endpackage

// File: rtl/fetch_instr_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_instr_queue_if
//   Bundles the fetch-side push port, the decode-side pop port, the flush
//   request and the occupancy output of the instruction queue.
//   Modports:
//     master : environment side (fetch + decode + redirect control)
//     slave  : the queue itself
//   Signals:
//     i_if_valid / o_if_ready / i_if_pc / i_if_instr / i_if_err  fetch push
//     o_id_valid / i_id_ready / o_id_pc / o_id_instr / o_id_err  decode pop
//     i_flush                                                    redirect
//     o_count                                                    occupancy
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface fetch_instr_queue_if
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int DEPTH      = IQ_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  i_if_valid;
    logic                  o_if_ready;
    logic [ADDR_WIDTH-1:0] i_if_pc;
    logic [DATA_WIDTH-1:0] i_if_instr;
    logic                  i_if_err;

    logic                  o_id_valid;
    logic                  i_id_ready;
    logic [ADDR_WIDTH-1:0] o_id_pc;
    logic [DATA_WIDTH-1:0] o_id_instr;
    logic                  o_id_err;

    logic                  i_flush;
    logic [CNT_W-1:0]      o_count;

    modport master (
        output i_if_valid, i_if_pc, i_if_instr, i_if_err,
        output i_id_ready, i_flush,
        input  o_if_ready, o_id_valid, o_id_pc, o_id_instr, o_id_err, o_count
    );

    modport slave (
        input  i_if_valid, i_if_pc, i_if_instr, i_if_err,
        input  i_id_ready, i_flush,
        output o_if_ready, o_id_valid, o_id_pc, o_id_instr, o_id_err, o_count
    );

endinterface

// File: rtl/fetch_instr_queue.sv
// ---------------------------------------------------------------------------
// fetch_instr_queue
//   In-order instruction queue between the fetch stage (AXI-lite read
//   master) and decode. Buffers up to DEPTH {pc, instr, err} entries so
//   fetch can keep reading while decode stalls; a synchronous flush drops
//   everything on a redirect. Head entry is presented first-word
//   fall-through straight from storage (no input-to-output bypass).
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : fetch_instr_queue_if.slave (push, pop, flush, occupancy)
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fetch_instr_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int DEPTH      = IQ_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_instr_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
        logic                  err;
    } entry_t;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_if_ready;

    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_push;
    logic             w_pop;
    entry_t           w_wr_entry;
    entry_t           w_entries [DEPTH];
    entry_t           w_head;

    assign w_wr_entry = '{pc: bus.i_if_pc, instr: bus.i_if_instr, err: bus.i_if_err};

    // Handshakes are qualified with !i_flush so a redirect cycle moves nothing.
    always_comb begin
        w_push        = bus.i_if_valid && r_if_ready && !bus.i_flush;
        w_pop         = (r_count != '0) && bus.i_id_ready && !bus.i_flush;
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        if (bus.i_flush) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            w_count_next  = '0;
        end else begin
            if (w_push) w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
            if (w_pop)  w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + CNT_W'(1);
                2'b01:   w_count_next = r_count - CNT_W'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    // Ready is registered from the next occupancy, so a pop while full only
    // reopens the fetch side one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_if_ready <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            r_if_ready <= (w_count_next != CNT_W'(DEPTH));
        end
    end

    // One register per slot; each slot loads only when it is the write target.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            entry_t r_entry;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_entry <= '0;
                end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_entry <= w_wr_entry;
                end
            end

            assign w_entries[gi] = r_entry;
        end
    endgenerate

    assign w_head         = w_entries[r_rd_ptr];

    assign bus.o_if_ready = r_if_ready;
    assign bus.o_id_valid = (r_count != '0);
    assign bus.o_id_pc    = w_head.pc;
    assign bus.o_id_instr = w_head.instr;
    assign bus.o_id_err   = w_head.err;
    assign bus.o_count    = r_count;

endmodule

// File: tb/tb_fetch_instr_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_instr_queue
//   Directed bench for fetch_instr_queue: reset release, streaming, fill and
//   stall, flush, error propagation and asynchronous reset mid-stream.
//   Inputs are driven 1 time unit after the rising edge, outputs sampled
//   there as well.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fetch_instr_queue;
    import fetch_pkg::*;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fails;

    fetch_instr_queue_if bus ();

    fetch_instr_queue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_val);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic v, input logic [31:0] pc,
                              input logic [31:0] instr, input logic err);
        bus.i_if_valid = v;
        bus.i_if_pc    = pc;
        bus.i_if_instr = instr;
        bus.i_if_err   = err;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        drive_push(1'b0, 32'h0, 32'h0, 1'b0);
        bus.i_id_ready = 1'b0;
        bus.i_flush    = 1'b0;

        // ---------------- reset release ----------------
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", 64'(bus.o_if_ready), 64'd0);
            chk("rst_valid", 64'(bus.o_id_valid), 64'd0);
            chk("rst_count", 64'(bus.o_count), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("rel_ready_pre", 64'(bus.o_if_ready), 64'd0);
        tick();
        chk("rel_ready", 64'(bus.o_if_ready), 64'd1);
        chk("rel_valid", 64'(bus.o_id_valid), 64'd0);
        chk("rel_count", 64'(bus.o_count), 64'd0);

        // ---------------- streaming ----------------
        bus.i_id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_push(1'b1, 32'(4 * i), 32'h0000_0013 + 32'(i << 7), 1'b0);
            tick();
            chk("str_valid", 64'(bus.o_id_valid), 64'd1);
            chk("str_pc",    64'(bus.o_id_pc), 64'(4 * i));
            chk("str_instr", 64'(bus.o_id_instr), 64'(32'h0000_0013 + 32'(i << 7)));
            chk("str_count", 64'(bus.o_count), 64'd1);
        end
        drive_push(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("str_empty_valid", 64'(bus.o_id_valid), 64'd0);
        chk("str_empty_count", 64'(bus.o_count), 64'd0);

        // ---------------- fill / stall ----------------
        bus.i_id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("fill_ready_pre", 64'(bus.o_if_ready), 64'd1);
            drive_push(1'b1, 32'h40 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
            tick();
            chk("fill_count", 64'(bus.o_count), 64'(i + 1));
        end
        chk("full_ready", 64'(bus.o_if_ready), 64'd0);
        chk("full_head",  64'(bus.o_id_pc), 64'h40);
        drive_push(1'b1, 32'h50, 32'hA000_0004, 1'b0);
        tick();
        chk("full_hold_count", 64'(bus.o_count), 64'd4);
        chk("full_hold_ready", 64'(bus.o_if_ready), 64'd0);
        bus.i_id_ready = 1'b1;
        tick();
        chk("pop_full_count", 64'(bus.o_count), 64'd3);
        chk("pop_full_ready", 64'(bus.o_if_ready), 64'd1);
        chk("pop_full_head",  64'(bus.o_id_pc), 64'h44);
        bus.i_id_ready = 1'b0;
        tick();
        chk("fifth_count", 64'(bus.o_count), 64'd4);
        chk("fifth_ready", 64'(bus.o_if_ready), 64'd0);
        drive_push(1'b0, 32'h0, 32'h0, 1'b0);
        bus.i_id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_pc",    64'(bus.o_id_pc), 64'(32'h44 + 32'(4 * k)));
            chk("drain_instr", 64'(bus.o_id_instr), 64'(32'hA000_0001 + 32'(k)));
            tick();
        end
        chk("drain_count", 64'(bus.o_count), 64'd0);
        chk("drain_valid", 64'(bus.o_id_valid), 64'd0);

        // ---------------- flush ----------------
        bus.i_id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_push(1'b1, 32'h60 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0);
            tick();
        end
        chk("pre_flush_count", 64'(bus.o_count), 64'd3);
        drive_push(1'b1, 32'h100, 32'hC000_0000, 1'b0);
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        chk("flush_count", 64'(bus.o_count), 64'd0);
        chk("flush_valid", 64'(bus.o_id_valid), 64'd0);
        chk("flush_ready", 64'(bus.o_if_ready), 64'd1);
        drive_push(1'b1, 32'h200, 32'hD000_0000, 1'b0);
        tick();
        drive_push(1'b0, 32'h0, 32'h0, 1'b0);
        chk("post_flush_valid", 64'(bus.o_id_valid), 64'd1);
        chk("post_flush_pc",    64'(bus.o_id_pc), 64'h200);
        chk("post_flush_count", 64'(bus.o_count), 64'd1);
        bus.i_id_ready = 1'b1;
        tick();
        chk("post_flush_empty", 64'(bus.o_count), 64'd0);

        // ---------------- error propagation ----------------
        bus.i_id_ready = 1'b0;
        drive_push(1'b1, 32'h4, 32'h0000_0093, 1'b0);
        tick();
        drive_push(1'b1, 32'h8, 32'h0000_0113, 1'b1);
        tick();
        drive_push(1'b1, 32'hC, 32'h0000_0193, 1'b0);
        tick();
        drive_push(1'b0, 32'h0, 32'h0, 1'b0);
        chk("err_count", 64'(bus.o_count), 64'd3);
        bus.i_id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("err_pc",   64'(bus.o_id_pc), 64'(32'h4 + 32'(4 * k)));
            chk("err_flag", 64'(bus.o_id_err), 64'(k == 1));
            tick();
        end
        chk("err_empty", 64'(bus.o_id_valid), 64'd0);

        // ---------------- asynchronous reset mid-stream ----------------
        bus.i_id_ready = 1'b0;
        drive_push(1'b1, 32'h300, 32'hE000_0000, 1'b0);
        tick();
        drive_push(1'b1, 32'h304, 32'hE000_0001, 1'b0);
        tick();
        drive_push(1'b0, 32'h0, 32'h0, 1'b0);
        chk("arst_pre_count", 64'(bus.o_count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.o_id_valid), 64'd0);
        chk("arst_ready", 64'(bus.o_if_ready), 64'd0);
        chk("arst_count", 64'(bus.o_count), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_rel_ready", 64'(bus.o_if_ready), 64'd1);
        chk("arst_rel_valid", 64'(bus.o_id_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_instr_queue.md
# fetch_instr_queue

Instruction queue between the `Fetch` stage (AXI-lite read master) and the decode stage. It accepts fetched words tagged with their PC and AXI-lite read-error status, buffers up to `DEPTH` entries, and presents them in order to decode through a valid/ready handshake. A synchronous flush discards all buffered entries on a control-flow redirect. Fetch can therefore keep issuing AXI-lite reads while decode stalls.

## Interface
- `ADDR_WIDTH`, default `` `ADDR_WIDTH `` (32): PC width.
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): instruction word width.
- `DEPTH`, default 4: number of entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_if_valid`  in  1  Fetch presents an entry.
- `o_if_ready`  out  1  queue can accept an entry (registered).
- `i_if_pc`  in  ADDR_WIDTH  PC of the presented word.
- `i_if_instr`  in  DATA_WIDTH  instruction word (AXI-lite RDATA).
- `i_if_err`  in  1  AXI-lite RRESP was not OKAY for this word.
- `o_id_valid`  out  1  head entry is valid.
- `i_id_ready`  in  1  decode consumes the head entry.
- `o_id_pc`  out  ADDR_WIDTH  head PC.
- `o_id_instr`  out  DATA_WIDTH  head instruction.
- `o_id_err`  out  1  head error flag.
- `i_flush`  in  1  discard all entries (redirect).
- `o_count`  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Circular buffer: `wr_ptr` and `rd_ptr` are each $clog2(DEPTH) bits and wrap naturally. `count` is 0..DEPTH.
- Push occurs when `i_if_valid && o_if_ready && !i_flush`. The entry {pc, instr, err} is written at `wr_ptr`, then `wr_ptr` increments.
- Pop occurs when `o_id_valid && i_id_ready && !i_flush`. `rd_ptr` increments.
- A push and a pop in the same cycle leave `count` unchanged. Push without pop gives +1; pop without push gives −1.
- Flush has priority over everything: `count`, `wr_ptr` and `rd_ptr` go to 0. A push or pop in the same cycle is ignored, and the offered entry is dropped.
- `o_id_valid = (count != 0)`. `o_id_*` are driven from `mem[rd_ptr]`, first-word fall-through from storage. There is no input-to-output bypass.
- `o_if_ready` is a register loaded each cycle with `(count_next != DEPTH)`.
- When full, `o_if_ready` is 0 even if decode pops in that cycle. It rises one cycle after the pop.
- `o_id_pc`, `o_id_instr` and `o_id_err` are don't-care while `o_id_valid` is 0.
- Entries are not reordered. `err` travels unmodified with its word.

## Timing
- Reset (`rst_n` low, asynchronous): `count`, `wr_ptr` and `rd_ptr` = 0; `o_if_ready` = 0; `o_id_valid` = 0; `o_count` = 0; storage cleared to 0.
- First rising edge after `rst_n` deasserts: `o_if_ready` goes to 1.
- Latency: an entry pushed at edge N is visible on `o_id_*` with `o_id_valid` = 1 from edge N until it is popped. Minimum fetch-to-decode latency is 1 cycle.
- Throughput: 1 entry/cycle sustained when 0 < count < DEPTH.
- Full (count = DEPTH): `o_if_ready` = 0. Fetch must hold `i_if_*` stable, per the AXI-lite-style valid/ready convention.
- Empty: `o_id_valid` = 0. A pop request is ignored.
- Flush at edge N: `o_id_valid` = 0 and `o_count` = 0 after N. `o_if_ready` = 1 after N. A push is accepted at the next edge.
- Reset asserted mid-operation: all state is cleared immediately, without waiting for a clock edge.

## Structure
- Shared package (`fetch_pkg`): the entry struct {pc, instr, err} and the `DEPTH` default. `ADDR_WIDTH` and `DATA_WIDTH` come from the existing global defines.
- Storage array, pointers and count stay inline. No sub-module is required.
- A generic `sync_fifo` sub-module is reasonable only if decode later needs a second queue.

## Test plan
- Reset release: hold `rst_n` low 3 cycles, then release. Require `o_if_ready` 0→1 one edge after release, and `o_id_valid` = 0 and `o_count` = 0 throughout.
- Streaming: push PCs 0x0, 0x4, 0x8, 0xC with instructions 0x00000013…, holding `i_id_ready` = 1. Require the same order on `o_id_*`, each exactly one cycle after its push, with `o_count` never exceeding 1.
- Fill/stall: with `i_id_ready` = 0, push 5 entries. Require `o_if_ready` = 0 after the 4th and `o_count` = 4. Then release `i_id_ready`: require the 5th entry to be accepted one cycle after the first pop.
- Flush: with 3 entries queued, assert `i_flush` together with a push of PC 0x100. Require `o_count` = 0 and `o_id_valid` = 0 next cycle. A following push of PC 0x200 must appear as the head.
- Error propagation: push PC 0x8 with `i_if_err` = 1 between two clean words. Require `o_id_err` = 1 only while PC 0x8 is at the head.
- Asynchronous reset mid-stream: with 2 entries queued, pull `rst_n` low between edges. Require `o_id_valid` = 0 and `o_if_ready` = 0 immediately, before the next edge.
